// File: rtl/prio_dec.sv
// rtl/prio_dec.sv - multi-cycle priority decoder: index -> one-hot + thermometer mask
// Optional PRIO_DEC_PASS_EN: accept a new index in the same cycle a result is taken.
module prio_dec #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] onehot,
    output logic [WIDTH-1:0] therm,
    output logic             err
);

    localparam int STEPS = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUILD, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [WIDTH:0]   acc_q, acc_d, acc_sh;
    logic [2:0]       step_q, step_d;
    logic             err_r_q, err_r_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic [WIDTH-1:0] therm_q, therm_d;
    logic [WIDTH-1:0] oh_w;
    logic             err_q, err_d;
    logic             accept;
    logic             xfer;

    assign out_valid = (state_q == DONE);
    assign xfer      = out_valid & out_ready;
    assign accept    = in_valid & in_ready;
    assign onehot    = onehot_q;
    assign therm     = therm_q;
    assign err       = err_q;

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
`ifdef PRIO_DEC_PASS_EN
            DONE:    in_ready = out_ready;
`else
            DONE:    in_ready = 1'b0;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    // One doubling step per cycle, MSB of the index first.
    always_comb begin
        acc_sh = idx_q[step_q] ? (acc_q << (1 << step_q)) : acc_q;
        oh_w   = acc_sh[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        step_d   = step_q;
        err_r_d  = err_r_q;
        onehot_d = onehot_q;
        therm_d  = therm_q;
        err_d    = err_q;
        case (state_q)
            IDLE: ;
            BUILD: begin
                acc_d  = acc_sh;
                step_d = step_q - 3'd1;
                if (step_q == 3'd0) begin
                    state_d  = DONE;
                    onehot_d = err_r_q ? '0 : oh_w;
                    therm_d  = err_r_q ? '0 : (oh_w | (oh_w - WIDTH'(1)));
                    err_d    = err_r_q;
                end
            end
            DONE: begin
                if (xfer) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new index can only be accepted from IDLE, or from DONE in pass-through mode.
        if (accept) begin
            state_d = BUILD;
            idx_d   = idx;
            acc_d   = {{WIDTH{1'b0}}, 1'b1};
            err_r_d = ({1'b0, idx} >= 9'(WIDTH));
            step_d  = 3'(STEPS - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            err_r_q  <= 1'b0;
            onehot_q <= '0;
            therm_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            err_r_q  <= err_r_d;
            onehot_q <= onehot_d;
            therm_q  <= therm_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_prio_dec.sv
// tb/tb_prio_dec.sv - self-checking bench for prio_dec with a behavioural reference model
module tb_prio_dec;

    localparam int WIDTH = 16;
    localparam int STEPS = 4;
`ifdef PRIO_DEC_PASS_EN
    localparam int SPACING = STEPS + 1;
`else
    localparam int SPACING = STEPS + 2;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       idx;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] onehot;
    logic [WIDTH-1:0] therm;
    logic             err;

    int n_chk  = 0;
    int n_fail = 0;

    prio_dec #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .idx       (idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .onehot    (onehot),
        .therm     (therm),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] m_onehot(input int i);
        longint v;
        v = (i < WIDTH) ? (longint'(1) << i) : 0;
        return WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] m_therm(input int i);
        longint v;
        v = (i < WIDTH) ? ((longint'(1) << (i + 1)) - 1) : 0;
        return WIDTH'(v);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one index from IDLE and waits (bounded) for out_valid; leaves the DUT in DONE.
    task automatic run_one(input logic [7:0] v, output int lat, output logic [WIDTH-1:0] oh,
                           output logic [WIDTH-1:0] th, output logic e);
        in_valid = 1'b1;
        idx      = v;
        tick;
        in_valid = 1'b0;
        idx      = 8'($urandom);
        lat      = 0;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
        oh = onehot;
        th = therm;
        e  = err;
    endtask

    task automatic test_reset;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        idx       = 8'd6;
        tick;
        in_valid = 1'b0;
        repeat (STEPS) tick;
        n_chk++;
        if (out_valid !== 1'b1 || onehot !== 16'h0040) begin
            n_fail++;
            $display("FAIL reset_precond: out_valid=%b onehot=%h expected 1 0040", out_valid, onehot);
        end
        #3 rst = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_chk++;
        if (onehot !== '0) begin n_fail++; $display("FAIL reset_onehot: got %h expected 0000", onehot); end
        n_chk++;
        if (therm !== '0) begin n_fail++; $display("FAIL reset_therm: got %h expected 0000", therm); end
        n_chk++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        tick;
        rst = 1'b0;
        tick;
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_decode;
        int lat;
        logic [WIDTH-1:0] oh, th;
        logic e;
        out_ready = 1'b1;
        run_one(8'd5, lat, oh, th, e);
        n_chk++;
        if (lat !== STEPS) begin n_fail++; $display("FAIL decode_latency: got %0d expected %0d", lat, STEPS); end
        n_chk++;
        if (oh !== 16'h0020) begin n_fail++; $display("FAIL decode_onehot: got %h expected 0020", oh); end
        n_chk++;
        if (th !== 16'h003F) begin n_fail++; $display("FAIL decode_therm: got %h expected 003f", th); end
        n_chk++;
        if (e !== 1'b0) begin n_fail++; $display("FAIL decode_err: got %b expected 0", e); end
        tick;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL decode_return: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_boundaries;
        int vals[5] = '{0, 15, 16, 200, 255};
        int lat;
        logic [WIDTH-1:0] oh, th;
        logic e;
        out_ready = 1'b1;
        foreach (vals[k]) begin
            run_one(8'(vals[k]), lat, oh, th, e);
            n_chk++;
            if (lat !== STEPS || oh !== m_onehot(vals[k]) || th !== m_therm(vals[k]) || e !== (vals[k] >= WIDTH)) begin
                n_fail++;
                $display("FAIL boundary idx=%0d: lat=%0d oh=%h th=%h err=%b expected lat=%0d oh=%h th=%h err=%b",
                         vals[k], lat, oh, th, e, STEPS, m_onehot(vals[k]), m_therm(vals[k]), vals[k] >= WIDTH);
            end
            tick;
        end
    endtask

    task automatic test_random;
        int lat, v, d;
        logic [WIDTH-1:0] oh, th;
        logic e;
        for (int n = 0; n < 40; n++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, WIDTH - 1));
            out_ready = 1'b0;
            run_one(8'(v), lat, oh, th, e);
            d = $urandom_range(0, 3);
            repeat (d) tick;
            n_chk++;
            if (lat !== STEPS || onehot !== m_onehot(v) || therm !== m_therm(v) || err !== (v >= WIDTH)) begin
                n_fail++;
                $display("FAIL random idx=%0d: lat=%0d oh=%h th=%h err=%b expected oh=%h th=%h err=%b",
                         v, lat, onehot, therm, err, m_onehot(v), m_therm(v), v >= WIDTH);
            end
            out_ready = 1'b1;
            tick;
            n_chk++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL random_drain idx=%0d: out_valid=%b expected 0", v, out_valid); end
        end
    endtask

    task automatic test_backpressure;
        int lat, n_xfer;
        logic [WIDTH-1:0] oh, th;
        logic e;
        n_xfer    = 0;
        out_ready = 1'b0;
        run_one(8'd9, lat, oh, th, e);
        n_chk++;
        if (lat !== STEPS || oh !== 16'h0200) begin
            n_fail++;
            $display("FAIL bp_first: lat=%0d oh=%h expected %0d 0200", lat, oh, STEPS);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            idx      = 8'd3;
            #1;
            n_chk++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || onehot !== 16'h0200 || therm !== 16'h03FF) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d: in_ready=%b out_valid=%b oh=%h th=%h expected 0 1 0200 03ff",
                         i, in_ready, out_valid, onehot, therm);
            end
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid && out_ready) n_xfer++;
            tick;
        end
        n_chk++;
        if (n_xfer !== 1) begin n_fail++; $display("FAIL bp_transfers: got %0d expected 1", n_xfer); end
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle: in_ready=%b expected 1", in_ready); end
    endtask

    task automatic test_abort;
        int lat, seen;
        logic [WIDTH-1:0] oh, th;
        logic e;
        seen      = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        idx       = 8'd7;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reset: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        tick;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick;
        end
        n_chk++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_no_result: out_valid cycles=%0d expected 0", seen); end
        run_one(8'd2, lat, oh, th, e);
        n_chk++;
        if (lat !== STEPS || oh !== 16'h0004 || th !== 16'h0007) begin
            n_fail++;
            $display("FAIL abort_next: lat=%0d oh=%h th=%h expected %0d 0004 0007", lat, oh, th, STEPS);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int acc_cyc[$];
        logic [WIDTH-1:0] res[$];
        int cyc, nxt;
        logic took;
        cyc       = 0;
        nxt       = 1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        idx       = 8'd1;
        while ((acc_cyc.size() < 3 || res.size() < 3) && cyc < 60) begin
            took = 1'b0;
            if (out_valid && out_ready) res.push_back(onehot);
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                took = 1'b1;
            end
            tick;
            cyc++;
            if (took) begin
                nxt++;
                if (nxt > 3) in_valid = 1'b0;
                else idx = 8'(nxt);
            end
        end
        in_valid = 1'b0;
        n_chk++;
        if (acc_cyc.size() !== 3 || res.size() !== 3) begin
            n_fail++;
            $display("FAIL stream_count: accepts=%0d results=%0d expected 3 3", acc_cyc.size(), res.size());
        end else begin
            for (int k = 1; k < 3; k++) begin
                n_chk++;
                if (acc_cyc[k] - acc_cyc[k-1] !== SPACING) begin
                    n_fail++;
                    $display("FAIL stream_spacing %0d: got %0d expected %0d", k, acc_cyc[k] - acc_cyc[k-1], SPACING);
                end
            end
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (res[k] !== m_onehot(k + 1)) begin
                    n_fail++;
                    $display("FAIL stream_result %0d: got %h expected %h", k, res[k], m_onehot(k + 1));
                end
            end
        end
        repeat (2) tick;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        idx       = 8'd0;
        out_ready = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
        tick;
        test_reset;
        test_decode;
        test_boundaries;
        test_random;
        test_backpressure;
        test_abort;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
